atto: RTL and testbench
=======================

Name: atto

Overview:
- Single-cycle-arbitrated mesh router node with two network inputs (north, east) and two network outputs (south, west), plus a local processing-element (PE) port.
- Traffic moves westward first (X dimension), then southward (Y dimension). Flits addressed to this node are ejected to the PE with the 8-bit header stripped.
- Flit validity is carried by a 2-bit differential pair that toggles once per flit.

Parameters:
- X_LOCAL, 4'd0, X coordinate of this node.
- Y_LOCAL, 4'd0, Y coordinate of this node.
- FIFO_DEPTH, 4, entries per north/east input FIFO (power of two).

Ports:
- clka  in  1  clock; all logic on rising edge.
- rsta  in  1  reset, synchronous, active-high.
- north_channel_din  in  48  north flit.
- north_diff_pair_din  in  2  north valid pair.
- east_channel_din  in  48  east flit.
- east_diff_pair_din  in  2  east valid pair.
- pe_channel_din  in  48  PE-injected flit.
- pe_diff_pair_din  in  2  PE valid pair.
- south_channel_dout  out  48  south flit.
- south_diff_pair_dout  out  2  south valid pair.
- west_channel_dout  out  48  west flit.
- west_diff_pair_dout  out  2  west valid pair.
- pe_channel_dout  out  40  ejected payload, flit[39:0].
- pe_diff_pair_dout  out  2  PE ejection valid pair.
- r2pe_ack_dout  out  1  one-cycle pulse: PE flit forwarded.

Behaviour:
- Flit format: [47:44] dest X, [43:40] dest Y, [39:0] payload.
- Diff pair: the legal values are 2'b01 and 2'b10. A new flit is signalled when the sampled pair differs from the previously stored legal value on that input. Values 2'b00 and 2'b11 are ignored and do not update the stored value.
- Reset (rsta=1 at a clock edge):
  - All channel outputs are 0.
  - All diff pair outputs are 2'b10.
  - r2pe_ack_dout is 0.
  - All FIFOs are empty.
  - Stored input pairs are set to 2'b10.
  - Reset mid-operation discards all queued flits.
- Capture: a new north or east flit is written into that input's FIFO at the edge where its toggle is sampled. A new PE flit goes into a 1-entry PE holding register.
  - If a north or east FIFO is full, the incoming flit is dropped.
  - The PE must not inject again until r2pe_ack_dout pulses. A toggle arriving while the PE register is occupied is ignored.
- Routing of each head flit:
  - East and PE inputs: dest X != X_LOCAL goes west; else dest Y != Y_LOCAL goes south; else goes to the PE.
  - North input: dest Y != Y_LOCAL goes south; else goes to the PE.
- Arbitration per output, each cycle:
  - Each head may win at most one output.
  - South: round-robin between north and east; PE has lowest priority.
  - West: east has priority over PE.
  - PE ejection: round-robin between north and east; PE loopback has lowest priority.
  - Losers hold their head flit.
- Output: at the edge after capture, a winning head drives the output register (channel = full 48-bit flit; PE gets [39:0]) and toggles that output's diff pair (01<->10).
  - Latency from sampled input toggle to output toggle is 2 edges when uncontended.
  - Outputs hold their last value when idle.
- r2pe_ack_dout is high for exactly one cycle, on the cycle the PE register's flit is forwarded.
- There is no output backpressure; downstream always accepts.

Test Plan:
- Reset for 20 cycles with all input pairs at 2'b10 -> all outputs 0, all pairs 2'b10, no activity; deasserting reset produces no spurious flit.
- North 48'h210000000000, pair 10->01 -> two edges later south_channel_dout=48'h210000000000, south_diff_pair_dout=2'b01; west is unchanged.
- East 48'h121111111111, pair 01 (next cycle) -> west_channel_dout=48'h121111111111, west_diff_pair_dout=2'b01.
- PE 48'h333333333333, pair 01 -> west_channel_dout=48'h333333333333, west_diff_pair_dout=2'b10, r2pe_ack_dout pulses for 1 cycle.
- North 48'h120000000000 and east 48'h121111111111, both pairs 01->10 in the same cycle -> south gets 48'h120000000000 with pair 2'b10; west gets 48'h121111111111 with pair 2'b01; no drops.
- North and east both routed south for 3 cycles, then PE flit 48'h00xxxxxxxxxx (X=0, Y=0) -> south alternates north/east in round-robin order, no loss at FIFO_DEPTH=4; PE flit ejects pe_channel_dout=flit[39:0] with its pair toggling.

Source files
------------

// File: rtl/atto.sv
// atto: mesh router node with west-first then south routing, two input FIFOs
// (north, east), a one-entry PE injection register and a PE ejection port.
module atto #(
   parameter logic [3:0]  X_LOCAL    = 4'd0,
   parameter logic [3:0]  Y_LOCAL    = 4'd0,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clka,
   input  logic        rsta,
   input  logic [47:0] north_channel_din,
   input  logic [1:0]  north_diff_pair_din,
   input  logic [47:0] east_channel_din,
   input  logic [1:0]  east_diff_pair_din,
   input  logic [47:0] pe_channel_din,
   input  logic [1:0]  pe_diff_pair_din,
   output logic [47:0] south_channel_dout,
   output logic [1:0]  south_diff_pair_dout,
   output logic [47:0] west_channel_dout,
   output logic [1:0]  west_diff_pair_dout,
   output logic [39:0] pe_channel_dout,
   output logic [1:0]  pe_diff_pair_dout,
   output logic        r2pe_ack_dout
);

   localparam int unsigned AW         = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
   localparam int unsigned NORTH      = 0;
   localparam int unsigned EAST       = 1;

   typedef enum logic [1:0] {RT_WEST, RT_SOUTH, RT_LOCAL} route_e;
   typedef enum logic {PRI_NORTH, PRI_EAST} rr_e;

   function automatic logic pair_legal(input logic [1:0] p);
      return (p == 2'b01) || (p == 2'b10);
   endfunction

   function automatic route_e route_xy(input logic [47:0] f);
      if (f[47:44] != X_LOCAL)
         return RT_WEST;
      else if (f[43:40] != Y_LOCAL)
         return RT_SOUTH;
      else
         return RT_LOCAL;
   endfunction

   logic [47:0] fifo_mem [2][FIFO_DEPTH];
   logic [AW-1:0] wr_ptr [2];
   logic [AW-1:0] rd_ptr [2];
   logic [AW:0]   count  [2];
   logic [1:0]    pair_q [2];
   logic [47:0]   din    [2];
   logic [1:0]    pair_in [2];
   logic [47:0]   head   [2];
   logic [1:0]    head_valid;
   logic [1:0]    push;
   logic [1:0]    pop;

   logic        pe_valid;
   logic [47:0] pe_flit;
   logic [1:0]  pe_pair_q;
   logic        pe_capture;
   logic        pe_fwd;

   rr_e rr_south;
   rr_e rr_eject;

   route_e n_route, e_route, p_route;
   logic n_s, n_x, e_s, e_w, e_x, p_s, p_w, p_x;
   logic gs_n, gs_e, gs_p, gw_e, gw_p, gx_n, gx_e, gx_p;
   logic [47:0] south_next;
   logic [47:0] west_next;
   logic [39:0] eject_next;

   always_comb begin
      din[NORTH]     = north_channel_din;
      din[EAST]      = east_channel_din;
      pair_in[NORTH] = north_diff_pair_din;
      pair_in[EAST]  = east_diff_pair_din;
   end

   // A full FIFO drops the arriving flit even if its head leaves on the same edge.
   always_comb begin
      push       = '0;
      head_valid = '0;
      for (int unsigned i = 0; i < 2; i++) begin
         head[i]       = fifo_mem[i][rd_ptr[i]];
         head_valid[i] = (count[i] != '0);
         push[i]       = pair_legal(pair_in[i]) && (pair_in[i] != pair_q[i]) &&
                         (count[i] != FULL_COUNT);
      end
      pe_capture = pair_legal(pe_diff_pair_din) && (pe_diff_pair_din != pe_pair_q) && !pe_valid;
   end

   always_comb begin
      n_route = (head[NORTH][43:40] != Y_LOCAL) ? RT_SOUTH : RT_LOCAL;
      e_route = route_xy(head[EAST]);
      p_route = route_xy(pe_flit);

      n_s = head_valid[NORTH] && (n_route == RT_SOUTH);
      n_x = head_valid[NORTH] && (n_route == RT_LOCAL);
      e_s = head_valid[EAST]  && (e_route == RT_SOUTH);
      e_w = head_valid[EAST]  && (e_route == RT_WEST);
      e_x = head_valid[EAST]  && (e_route == RT_LOCAL);
      p_s = pe_valid && (p_route == RT_SOUTH);
      p_w = pe_valid && (p_route == RT_WEST);
      p_x = pe_valid && (p_route == RT_LOCAL);

      gs_n = n_s && (!e_s || (rr_south == PRI_NORTH));
      gs_e = e_s && (!n_s || (rr_south == PRI_EAST));
      gs_p = p_s && !n_s && !e_s;
      gw_e = e_w;
      gw_p = p_w && !e_w;
      gx_n = n_x && (!e_x || (rr_eject == PRI_NORTH));
      gx_e = e_x && (!n_x || (rr_eject == PRI_EAST));
      gx_p = p_x && !n_x && !e_x;

      pop[NORTH] = gs_n || gx_n;
      pop[EAST]  = gs_e || gw_e || gx_e;
      pe_fwd     = gs_p || gw_p || gx_p;

      south_next = gs_n ? head[NORTH] : (gs_e ? head[EAST] : pe_flit);
      west_next  = gw_e ? head[EAST] : pe_flit;
      eject_next = gx_n ? head[NORTH][39:0] : (gx_e ? head[EAST][39:0] : pe_flit[39:0]);
   end

   always_ff @(posedge clka) begin
      for (int unsigned i = 0; i < 2; i++)
         if (push[i])
            fifo_mem[i][wr_ptr[i]] <= din[i];
   end

   always_ff @(posedge clka) begin
      if (rsta) begin
         for (int unsigned i = 0; i < 2; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
            pair_q[i] <= 2'b10;
         end
      end else begin
         for (int unsigned i = 0; i < 2; i++) begin
            if (pair_legal(pair_in[i]))
               pair_q[i] <= pair_in[i];
            if (push[i])
               wr_ptr[i] <= wr_ptr[i] + AW'(1);
            if (pop[i])
               rd_ptr[i] <= rd_ptr[i] + AW'(1);
            case ({push[i], pop[i]})
               2'b10:   count[i] <= count[i] + (AW + 1)'(1);
               2'b01:   count[i] <= count[i] - (AW + 1)'(1);
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clka) begin
      if (rsta) begin
         south_channel_dout   <= '0;
         south_diff_pair_dout <= 2'b10;
         west_channel_dout    <= '0;
         west_diff_pair_dout  <= 2'b10;
         pe_channel_dout      <= '0;
         pe_diff_pair_dout    <= 2'b10;
         r2pe_ack_dout        <= 1'b0;
         pe_valid             <= 1'b0;
         pe_flit              <= '0;
         pe_pair_q            <= 2'b10;
         rr_south             <= PRI_NORTH;
         rr_eject             <= PRI_NORTH;
      end else begin
         r2pe_ack_dout <= pe_fwd;
         if (gs_n || gs_e || gs_p) begin
            south_channel_dout   <= south_next;
            south_diff_pair_dout <= ~south_diff_pair_dout;
         end
         if (gw_e || gw_p) begin
            west_channel_dout   <= west_next;
            west_diff_pair_dout <= ~west_diff_pair_dout;
         end
         if (gx_n || gx_e || gx_p) begin
            pe_channel_dout   <= eject_next;
            pe_diff_pair_dout <= ~pe_diff_pair_dout;
         end
         if (gs_n)
            rr_south <= PRI_EAST;
         else if (gs_e)
            rr_south <= PRI_NORTH;
         if (gx_n)
            rr_eject <= PRI_EAST;
         else if (gx_e)
            rr_eject <= PRI_NORTH;
         if (pe_fwd)
            pe_valid <= 1'b0;
         else if (pe_capture) begin
            pe_valid <= 1'b1;
            pe_flit  <= pe_channel_din;
         end
         if (pair_legal(pe_diff_pair_din))
            pe_pair_q <= pe_diff_pair_din;
      end
   end

endmodule

// File: tb/tb_atto.sv
// Bench for atto: directed scenarios followed by random traffic, all checked
// cycle by cycle against a queue-based model of the routing rules.
module tb_atto;

   localparam int unsigned DEPTH   = 4;
   localparam int          D_WEST  = 0;
   localparam int          D_SOUTH = 1;
   localparam int          D_LOCAL = 2;

   logic        clka = 1'b0;
   logic        rsta;
   logic [47:0] n_din, e_din, p_din;
   logic [1:0]  n_pair, e_pair, p_pair;
   logic [47:0] south_channel_dout, west_channel_dout;
   logic [1:0]  south_diff_pair_dout, west_diff_pair_dout, pe_diff_pair_dout;
   logic [39:0] pe_channel_dout;
   logic        r2pe_ack_dout;

   always #5 clka = ~clka;

   atto #(.X_LOCAL(4'd0), .Y_LOCAL(4'd0), .FIFO_DEPTH(DEPTH)) dut (
      .clka                 (clka),
      .rsta                 (rsta),
      .north_channel_din    (n_din),
      .north_diff_pair_din  (n_pair),
      .east_channel_din     (e_din),
      .east_diff_pair_din   (e_pair),
      .pe_channel_din       (p_din),
      .pe_diff_pair_din     (p_pair),
      .south_channel_dout   (south_channel_dout),
      .south_diff_pair_dout (south_diff_pair_dout),
      .west_channel_dout    (west_channel_dout),
      .west_diff_pair_dout  (west_diff_pair_dout),
      .pe_channel_dout      (pe_channel_dout),
      .pe_diff_pair_dout    (pe_diff_pair_dout),
      .r2pe_ack_dout        (r2pe_ack_dout)
   );

   int unsigned checks = 0;
   int unsigned errors = 0;

   task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Model state: per-input queues, PE holding slot, last round-robin winners.
   logic [47:0] mq_n[$];
   logic [47:0] mq_e[$];
   logic        m_pe_valid;
   logic [47:0] m_pe_flit;
   logic [1:0]  m_seen_n, m_seen_e, m_seen_p;
   bit          m_last_s_east, m_last_x_east;
   logic [47:0] m_south, m_west;
   logic [39:0] m_pe_out;
   logic [1:0]  m_sp, m_wp, m_pp;
   logic        m_ack;

   function automatic bit legal(input logic [1:0] p);
      return (p == 2'b01) || (p == 2'b10);
   endfunction

   function automatic int dest_of(input logic [47:0] f, input bit from_north);
      if (!from_north && f[47:44] != 4'd0) return D_WEST;
      if (f[43:40] != 4'd0) return D_SOUTH;
      return D_LOCAL;
   endfunction

   // 0 = north, 1 = east, 2 = PE, -1 = nobody
   function automatic int pick(input bit n_req, input bit e_req, input bit p_req, input bit last_east);
      if (n_req && e_req) return last_east ? 0 : 1;
      if (n_req) return 0;
      if (e_req) return 1;
      if (p_req) return 2;
      return -1;
   endfunction

   task automatic model_edge();
      int dn, de, dp, ws, ww, wx;
      bit full_n, full_e, pe_was;
      logic [47:0] hn, he;
      if (rsta) begin
         mq_n.delete();
         mq_e.delete();
         m_pe_valid = 1'b0;
         m_pe_flit  = '0;
         m_seen_n = 2'b10; m_seen_e = 2'b10; m_seen_p = 2'b10;
         m_south = '0; m_west = '0; m_pe_out = '0;
         m_sp = 2'b10; m_wp = 2'b10; m_pp = 2'b10;
         m_ack = 1'b0;
         m_last_s_east = 1'b1;
         m_last_x_east = 1'b1;
         return;
      end
      hn = (mq_n.size() > 0) ? mq_n[0] : '0;
      he = (mq_e.size() > 0) ? mq_e[0] : '0;
      dn = (mq_n.size() > 0) ? dest_of(hn, 1'b1) : -1;
      de = (mq_e.size() > 0) ? dest_of(he, 1'b0) : -1;
      dp = m_pe_valid ? dest_of(m_pe_flit, 1'b0) : -1;
      ws = pick(dn == D_SOUTH, de == D_SOUTH, dp == D_SOUTH, m_last_s_east);
      ww = pick(1'b0, de == D_WEST, dp == D_WEST, 1'b0);
      wx = pick(dn == D_LOCAL, de == D_LOCAL, dp == D_LOCAL, m_last_x_east);
      full_n = mq_n.size() >= DEPTH;
      full_e = mq_e.size() >= DEPTH;
      pe_was = m_pe_valid;
      m_ack  = 1'b0;
      if (ws >= 0) begin
         m_south = (ws == 0) ? hn : ((ws == 1) ? he : m_pe_flit);
         m_sp = ~m_sp;
         if (ws < 2) m_last_s_east = (ws == 1);
      end
      if (ww >= 0) begin
         m_west = (ww == 1) ? he : m_pe_flit;
         m_wp = ~m_wp;
      end
      if (wx >= 0) begin
         m_pe_out = (wx == 0) ? hn[39:0] : ((wx == 1) ? he[39:0] : m_pe_flit[39:0]);
         m_pp = ~m_pp;
         if (wx < 2) m_last_x_east = (wx == 1);
      end
      if (ws == 0 || wx == 0) void'(mq_n.pop_front());
      if (ws == 1 || ww == 1 || wx == 1) void'(mq_e.pop_front());
      if (ws == 2 || ww == 2 || wx == 2) begin
         m_pe_valid = 1'b0;
         m_ack = 1'b1;
      end
      if (legal(n_pair)) begin
         if (n_pair != m_seen_n && !full_n) mq_n.push_back(n_din);
         m_seen_n = n_pair;
      end
      if (legal(e_pair)) begin
         if (e_pair != m_seen_e && !full_e) mq_e.push_back(e_din);
         m_seen_e = e_pair;
      end
      if (legal(p_pair)) begin
         if (p_pair != m_seen_p && !pe_was) begin
            m_pe_valid = 1'b1;
            m_pe_flit  = p_din;
         end
         m_seen_p = p_pair;
      end
   endtask

   task automatic compare_all();
      chk("south_ch",   south_channel_dout, m_south);
      chk("south_pair", 48'(south_diff_pair_dout), 48'(m_sp));
      chk("west_ch",    west_channel_dout, m_west);
      chk("west_pair",  48'(west_diff_pair_dout), 48'(m_wp));
      chk("pe_ch",      48'(pe_channel_dout), 48'(m_pe_out));
      chk("pe_pair",    48'(pe_diff_pair_dout), 48'(m_pp));
      chk("ack",        48'(r2pe_ack_dout), 48'(m_ack));
   endtask

   // Called at a falling edge with inputs already set; returns at the next falling edge.
   task automatic step();
      model_edge();
      @(posedge clka);
      #1;
      compare_all();
      @(negedge clka);
   endtask

   function automatic logic [47:0] rand_flit();
      logic [47:0] f;
      f[47:44] = 4'($urandom_range(0, 2));
      f[43:40] = 4'($urandom_range(0, 2));
      f[39:32] = 8'($urandom);
      f[31:0]  = $urandom;
      return f;
   endfunction

   initial begin
      logic [47:0] s_seen[$];
      logic [1:0]  prev_sp;
      logic [1:0]  n_leg, e_leg, p_leg;
      int unsigned r;
      int unsigned n_a0;

      rsta = 1'b1;
      n_din = '0; e_din = '0; p_din = '0;
      n_pair = 2'b10; e_pair = 2'b10; p_pair = 2'b10;
      @(negedge clka);

      for (int i = 0; i < 20; i++) step();
      chk("rst_south_ch", south_channel_dout, 48'h0);
      chk("rst_pairs", 48'({south_diff_pair_dout, west_diff_pair_dout, pe_diff_pair_dout}), 48'(6'b101010));
      chk("rst_pe_ch", 48'(pe_channel_dout), 48'h0);
      chk("rst_ack", 48'(r2pe_ack_dout), 48'h0);

      rsta = 1'b0;
      for (int i = 0; i < 3; i++) step();
      chk("post_rst_quiet", 48'({south_diff_pair_dout, west_diff_pair_dout, pe_diff_pair_dout}), 48'(6'b101010));

      n_din = 48'h210000000000; n_pair = 2'b01;
      step(); step();
      chk("n_south_ch", south_channel_dout, 48'h210000000000);
      chk("n_south_pair", 48'(south_diff_pair_dout), 48'(2'b01));
      chk("n_west_idle", 48'(west_diff_pair_dout), 48'(2'b10));

      e_din = 48'h121111111111; e_pair = 2'b01;
      step(); step();
      chk("e_west_ch", west_channel_dout, 48'h121111111111);
      chk("e_west_pair", 48'(west_diff_pair_dout), 48'(2'b01));

      p_din = 48'h333333333333; p_pair = 2'b01;
      step(); step();
      chk("pe_west_ch", west_channel_dout, 48'h333333333333);
      chk("pe_west_pair", 48'(west_diff_pair_dout), 48'(2'b10));
      chk("pe_ack_hi", 48'(r2pe_ack_dout), 48'h1);
      step();
      chk("pe_ack_lo", 48'(r2pe_ack_dout), 48'h0);

      n_din = 48'h120000000000; n_pair = 2'b10;
      e_din = 48'h121111111111; e_pair = 2'b10;
      step(); step();
      chk("dual_south_ch", south_channel_dout, 48'h120000000000);
      chk("dual_south_pair", 48'(south_diff_pair_dout), 48'(2'b10));
      chk("dual_west_ch", west_channel_dout, 48'h121111111111);
      chk("dual_west_pair", 48'(west_diff_pair_dout), 48'(2'b01));

      prev_sp = south_diff_pair_dout;
      for (int k = 0; k < 12; k++) begin
         if (k < 3) begin
            n_din = {8'h01, 8'hA0, 32'(k)}; n_pair = ~n_pair;
            e_din = {8'h01, 8'hB0, 32'(k)}; e_pair = ~e_pair;
         end
         if (k == 3) begin
            p_din = 48'h00ABCDEF0123; p_pair = ~p_pair;
         end
         step();
         if (south_diff_pair_dout != prev_sp) begin
            s_seen.push_back(south_channel_dout);
            prev_sp = south_diff_pair_dout;
         end
      end
      chk("rr_count", 48'(s_seen.size()), 48'd6);
      n_a0 = 0;
      for (int k = 0; k < s_seen.size(); k++) begin
         if (s_seen[k][39:32] == 8'hA0) n_a0++;
         if (k > 0) chk("rr_alternate", 48'(s_seen[k][39:32] != s_seen[k-1][39:32]), 48'd1);
      end
      chk("rr_north_share", 48'(n_a0), 48'd3);
      chk("eject_payload", 48'(pe_channel_dout), 48'h00ABCDEF0123);
      chk("eject_pair", 48'(pe_diff_pair_dout), 48'(2'b01));

      n_leg = n_pair; e_leg = e_pair; p_leg = p_pair;
      for (int c = 0; c < 3000; c++) begin
         rsta = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 2) == 0) n_din = rand_flit();
         if ($urandom_range(0, 2) == 0) e_din = rand_flit();
         r = $urandom_range(0, 9);
         if (r < 5) begin n_leg = ~n_leg; n_pair = n_leg; end
         else if (r == 5) n_pair = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
         else n_pair = n_leg;
         r = $urandom_range(0, 9);
         if (r < 5) begin e_leg = ~e_leg; e_pair = e_leg; end
         else if (r == 5) e_pair = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
         else e_pair = e_leg;
         r = $urandom_range(0, 9);
         if (!m_pe_valid && r < 4) begin
            p_din = rand_flit();
            p_leg = ~p_leg;
            p_pair = p_leg;
         end else if (r == 9) p_pair = 2'b11;
         else p_pair = p_leg;
         step();
      end

      rsta = 1'b1;
      step();
      chk("final_rst_ack", 48'(r2pe_ack_dout), 48'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
